// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit two's-complement subtractor, LSB first: D = A - B,
// formed as A + ~B + 1 through one full-adder slice and a carry flop.
// Reports the unsigned borrow (Bout) and the signed overflow of the result.
// Handshake: start is sampled in IDLE, busy is high for WIDTH cycles while
// the bits are processed, and done pulses for one cycle when D is valid.
// Optional build macro ADD_SUB_MODE_EN adds an 'op' input (1 = add, 0 = subtract).
// With op = 1, Bout reports the true carry out rather than the borrow.

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ADD_SUB_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             a_msb;
    logic             b_msb;

    logic             is_add;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] d_next;
    logic             ovf_nxt;

`ifdef ADD_SUB_MODE_EN
    logic             op_q;
    assign is_add = op_q;
`else
    assign is_add = 1'b0;
`endif

    // Full-adder slice on the current LSBs.
    // The final sum bit becomes the MSB of the result.
    assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign d_next    = {sum_bit, d_sr[WIDTH-1:1]};
    assign ovf_nxt   = is_add ? (~(a_msb ^ b_msb) & (sum_bit ^ a_msb))
                              : ( (a_msb ^ b_msb) & (sum_bit ^ a_msb));

    // Control FSM and datapath.
    // All outputs are registered and change only on the last RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
`ifdef ADD_SUB_MODE_EN
            op_q     <= 1'b0;
`endif
            D        <= '0;
            Bout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
`ifdef ADD_SUB_MODE_EN
                        op_q  <= op;
                        b_sr  <= op ? B : ~B;
                        carry <= ~op;
`else
                        b_sr  <= ~B;
                        carry <= 1'b1;
`endif
                        d_sr  <= '0;
                        cnt   <= '0;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_nxt;
                    d_sr  <= d_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        D        <= d_next;
                        Bout     <= is_add ? carry_nxt : ~carry_nxt;
                        overflow <= ovf_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit two's-complement subtractor: D = A - B, one bit per clock, LSB first.
- Computes A + ~B + 1 through a single full-adder slice plus a carry flop.
- Reports unsigned borrow and signed overflow.
- Companion to the combinational parallel adder. Trades latency for area and hands results back over a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on the accepted start edge
- B  input  WIDTH  subtrahend; captured on the accepted start edge
- D  output  WIDTH  difference; registered, held until next completion
- Bout  output  1  borrow out: 1 when unsigned A < B
- overflow  output  1  signed overflow of A - B
- busy  output  1  high while an operation is in flight (RUN)
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; D=0, Bout=0, overflow=0, busy=0, done=0. Shift registers, bit counter and carry cleared. Reset mid-operation aborts it; no done pulse.
- States:
  - IDLE: busy=0, done=0. start=1 at an edge captures A into a_sr and ~B into b_sr, sets carry=1, cnt=0, and moves to RUN.
  - RUN: busy=1. Each edge: s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0], b_sr[0], carry). a_sr and b_sr shift right. s shifts into d_sr from the MSB side. cnt++.
  - RUN exit: on the edge where cnt reaches WIDTH, load D <= final d_sr and Bout <= ~carry_out. Load overflow <= (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the captured operands. State moves to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge, i.e. WIDTH+1 edges from start capture to done visible.
- Back-to-back starts: minimum start-to-start spacing is WIDTH+2 cycles.
- start while RUN or DONE: ignored, not queued. A/B changes after capture have no effect.
- D, Bout and overflow change only on the RUN exit edge. They are stable in DONE and IDLE until the next completion.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: ADD_SUB_MODE_EN.
- Defined:
  - Adds port op (input, 1 bit, captured with A/B on the accepted start edge).
  - op=1 (add): load B uninverted and carry=0, so D = A + B. Bout then carries the true carry out (not inverted), and overflow = (A[MSB]==B[MSB]) && (D[MSB]!=A[MSB]).
  - op=0 (subtract): behaviour as above.
- Undefined: op port absent; always subtract.

Test Plan:
- Reset, then A=5, B=3, start pulse -> busy high 4 cycles; done one cycle; D=2, Bout=0, overflow=0.
- A=3, B=5 -> D=4'hE, Bout=1, overflow=0.
- A=4'h8, B=4'h1 (-8-1) -> D=4'h7, Bout=0, overflow=1.
- A=4'h7, B=4'hF (7-(-1)) -> D=4'h8, Bout=1, overflow=1.
- Second start asserted during RUN -> ignored; exactly one done. Separately, rst_n low mid-RUN -> all outputs 0 immediately, no done, next start works normally.
- ADD_SUB_MODE_EN, op=1, A=7, B=1 -> D=8, Bout=0, overflow=1. Separately, A=4'hF, B=4'h1 -> D=0, Bout=1, overflow=0.
